jtframe_pll_seq: RTL and testbench
==================================

// Module: jtframe_pll_seq
// PURPOSE
//  Sequences the MiSTer system PLL (50 MHz ref -> 48/48-shifted/6 MHz outputs).
//  Drives the PLL reset, qualifies the asynchronous 'locked' flag and releases
//  the core reset only after lock has been stable. Retries on timeout or lock loss.
//  Runs on the 50 MHz reference clock, which is valid before the PLL locks.
// PARAMETERS
//  RST_CYCLES    16       pll_rst pulse width, clk cycles (>=1)
//  STABLE_CYCLES 4096     consecutive locked cycles required before release
//  TIMEOUT       1048576  cycles in WAIT_LOCK before retry (~21 ms at 50 MHz)
//  MAX_RETRY     7        retries before fail is set (retry_cnt saturates here)
//  PHASE_CNT     5'd1     PLL counter select for phase stepping (outclk_1 = SDRAM)
// PORTS
//  clk            in   1  50 MHz reference clock, same net as PLL refclk
//  rst_n          in   1  async active-low reset
//  pll_locked     in   1  PLL locked, asynchronous to clk
//  pll_rst        out  1  PLL reset, active high
//  sys_rst        out  1  core reset, active high; low only in RUN
//  ready          out  1  high in RUN
//  fail           out  1  sticky: retry_cnt reached MAX_RETRY
//  retry_cnt      out  3  failed lock attempts, saturating
//  loss_cnt       out  8  lock losses while in RUN, saturating at 255
//  -- only with JTFRAME_PLL_PHASE_EN:
//  phase_req      in   1  one-cycle request to shift phase
//  phase_dir      in   1  1 = advance, 0 = delay
//  phase_steps    in   6  number of VCO steps (0..63)
//  phase_busy     out  1  phase operation in progress
//  pll_phasestep  out  1  to PLL phasestep
//  pll_updn       out  1  to PLL updn (latched phase_dir)
//  pll_cntsel     out  5  constant PHASE_CNT
//  pll_phasedone  in   1  from PLL, asynchronous, active-low while stepping
// BEHAVIOUR
//  - rst_n low (async): state=RESET, pll_rst=1, sys_rst=1, ready=0, fail=0,
//    counters 0, phase_busy=0, pll_phasestep=0. All outputs registered.
//  - pll_locked and pll_phasedone pass 2-FF synchronizers: 2-cycle latency (locked_s).
//  - RESET: pll_rst=1 for exactly RST_CYCLES cycles, then -> WAIT_LOCK.
//  - WAIT_LOCK: pll_rst=0, timer counts; locked_s=1 -> STABLE (timer cleared);
//    timer reaches TIMEOUT-1 -> RESET, retry_cnt+1 (saturating).
//  - STABLE: counts consecutive locked_s=1; any locked_s=0 -> WAIT_LOCK, timer
//    cleared, no retry increment. Count reaches STABLE_CYCLES -> RUN.
//  - RUN: sys_rst=0, ready=1, retry_cnt cleared to 0. locked_s=0 -> RESET,
//    sys_rst=1 and ready=0 in the same registered update, loss_cnt+1 (sat.).
//  - fail set when retry_cnt reaches MAX_RETRY; sticky until rst_n; retries continue.
//  - Re-entry to RESET always reruns the full RST_CYCLES pulse.
// CONFIGURATION
//  JTFRAME_PLL_PHASE_EN defined: phase ports present. phase_req honoured only
//  in RUN with phase_busy=0, else ignored (no queueing). phase_steps=0: no-op,
//  phase_busy stays 0. Otherwise latch dir/steps, phase_busy=1 next cycle;
//  per step: pll_phasestep=1 for 2 cycles, wait phasedone_s=0 then phasedone_s=1,
//  decrement; after last step phase_busy=0 next cycle. Leaving RUN aborts:
//  pll_phasestep=0, phase_busy=0, remaining steps dropped.
//  Undefined: phase ports absent, no phase logic generated.
// TESTING
//  1. rst_n release, locked rises 100 cycles after pll_rst falls -> pll_rst high
//     16 cycles; sys_rst falls 4096 cycles after locked_s; ready=1.
//  2. locked never rises (TIMEOUT=1000) -> pll_rst repulses every 1016 cycles;
//     retry_cnt reaches 7 and saturates; fail=1 sticky.
//  3. locked glitch low 3 cycles during STABLE -> back to WAIT_LOCK, full 4096
//     restarted, retry_cnt unchanged.
//  4. locked drops in RUN -> sys_rst=1 within 3 cycles, loss_cnt=1, full resequence;
//     256 losses -> loss_cnt=255.
//  5. PHASE_EN: req dir=1 steps=3, model phasedone low 4 cycles per step ->
//     3 phasestep pulses of 2 cycles, updn=1, cntsel=1, busy clears after 3rd.
//  6. PHASE_EN: locked drops after step 1 of 5 -> busy=0, phasestep=0, no more pulses.

Source files
------------

// File: rtl/jtframe_pll_seq.sv
// jtframe_pll_seq
// ----------------------------------------------------------------------------
// Power-up / recovery sequencer for the MiSTer system PLL (50 MHz reference ->
// 48 MHz, 48 MHz shifted and 6 MHz outputs). It runs entirely on the 50 MHz
// reference clock, which is valid before the PLL locks, so it can pulse the
// PLL reset, qualify the asynchronous lock flag and release the core reset
// only after lock has been continuously stable for a while. It retries on
// lock timeout and resequences when lock is lost during normal operation.
//
// Optional feature macro: JTFRAME_PLL_PHASE_EN
//   When defined, a dynamic phase-shift engine is added. It drives the PLL
//   phasestep/updn/cntsel pins and is only usable while the sequencer is in
//   RUN. When undefined, the phase ports and logic are absent.
//
// Ports
//   clk            in   50 MHz reference clock (same net as the PLL refclk)
//   rst_n          in   asynchronous active-low reset
//   pll_locked     in   PLL locked flag, asynchronous to clk
//   pll_rst        out  PLL reset, active high
//   sys_rst        out  core reset, active high; low only in RUN
//   ready          out  high while in RUN
//   fail           out  sticky: retry_cnt reached MAX_RETRY
//   retry_cnt[2:0] out  failed lock attempts, saturating at MAX_RETRY
//   loss_cnt[7:0]  out  lock losses while in RUN, saturating at 255
//   (JTFRAME_PLL_PHASE_EN only)
//   phase_req      in   one-cycle phase shift request
//   phase_dir      in   1 = advance, 0 = delay
//   phase_steps    in   number of VCO steps (0..63)
//   phase_busy     out  phase operation in progress
//   pll_phasestep  out  to PLL phasestep
//   pll_updn       out  to PLL updn (latched phase_dir)
//   pll_cntsel     out  constant PHASE_CNT
//   pll_phasedone  in   from PLL, asynchronous, low while a step is applied
// ----------------------------------------------------------------------------
module jtframe_pll_seq #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned STABLE_CYCLES = 4096,
    parameter int unsigned TIMEOUT       = 1048576,
    parameter int unsigned MAX_RETRY     = 7
`ifdef JTFRAME_PLL_PHASE_EN
    ,
    parameter logic [4:0]  PHASE_CNT     = 5'd1
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fail,
    output logic [2:0] retry_cnt,
    output logic [7:0] loss_cnt
`ifdef JTFRAME_PLL_PHASE_EN
    ,
    input  logic       phase_req,
    input  logic       phase_dir,
    input  logic [5:0] phase_steps,
    output logic       phase_busy,
    output logic       pll_phasestep,
    output logic       pll_updn,
    output logic [4:0] pll_cntsel,
    input  logic       pll_phasedone
`endif
);

    // One shared timer serves the reset pulse, the lock timeout and the
    // stability count, so it is sized for the largest of the three.
    localparam int unsigned T_MAX_A = (TIMEOUT > STABLE_CYCLES) ? TIMEOUT : STABLE_CYCLES;
    localparam int unsigned T_MAX   = (T_MAX_A > RST_CYCLES) ? T_MAX_A : RST_CYCLES;
    localparam int unsigned TW      = $clog2(T_MAX + 1);

    localparam logic [TW-1:0] RST_LAST    = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] STABLE_LAST = TW'(STABLE_CYCLES - 1);
    localparam logic [2:0]    RETRY_MAX   = 3'(MAX_RETRY);

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_WAIT   = 2'd1,
        ST_STABLE = 2'd2,
        ST_RUN    = 2'd3
    } state_t;

    state_t         state_q;
    logic [TW-1:0]  timer_q;
    logic           locked_meta_q;
    logic           locked_s_q;
    logic           pll_rst_q;
    logic           sys_rst_q;
    logic           ready_q;
    logic           fail_q;
    logic [2:0]     retry_q;
    logic [7:0]     loss_q;

`ifdef JTFRAME_PLL_PHASE_EN
    typedef enum logic [1:0] {
        PH_IDLE  = 2'd0,
        PH_PULSE = 2'd1,
        PH_WLOW  = 2'd2,
        PH_WHIGH = 2'd3
    } ph_state_t;

    ph_state_t      ph_state_q;
    logic [5:0]     steps_q;
    logic           pulse_q;
    logic           busy_q;
    logic           phasestep_q;
    logic           updn_q;
    logic           done_meta_q;
    logic           done_s_q;

    // The phase engine may only act while the sequencer stays in RUN across
    // this edge; a lock loss aborts it on the same edge RUN is left.
    logic           stay_run;
    assign stay_run = (state_q == ST_RUN) && locked_s_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RESET;
            timer_q       <= '0;
            locked_meta_q <= 1'b0;
            locked_s_q    <= 1'b0;
            pll_rst_q     <= 1'b1;
            sys_rst_q     <= 1'b1;
            ready_q       <= 1'b0;
            fail_q        <= 1'b0;
            retry_q       <= '0;
            loss_q        <= '0;
`ifdef JTFRAME_PLL_PHASE_EN
            ph_state_q    <= PH_IDLE;
            steps_q       <= '0;
            pulse_q       <= 1'b0;
            busy_q        <= 1'b0;
            phasestep_q   <= 1'b0;
            updn_q        <= 1'b0;
            done_meta_q   <= 1'b1;
            done_s_q      <= 1'b1;
`endif
        end else begin
            locked_meta_q <= pll_locked;
            locked_s_q    <= locked_meta_q;

            case (state_q)
                ST_RESET: begin
                    pll_rst_q <= 1'b1;
                    sys_rst_q <= 1'b1;
                    ready_q   <= 1'b0;
                    if (timer_q == RST_LAST) begin
                        state_q   <= ST_WAIT;
                        pll_rst_q <= 1'b0;
                        timer_q   <= '0;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (locked_s_q) begin
                        state_q <= ST_STABLE;
                        timer_q <= '0;
                    end else if (timer_q == TO_LAST) begin
                        // Lock never came: rerun the full reset pulse.
                        state_q   <= ST_RESET;
                        pll_rst_q <= 1'b1;
                        timer_q   <= '0;
                        if (retry_q != RETRY_MAX) begin
                            retry_q <= retry_q + 3'd1;
                            if ((retry_q + 3'd1) == RETRY_MAX) begin
                                fail_q <= 1'b1;
                            end
                        end
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                ST_STABLE: begin
                    // Any dropout restarts qualification without counting
                    // as a failed attempt.
                    if (!locked_s_q) begin
                        state_q <= ST_WAIT;
                        timer_q <= '0;
                    end else if (timer_q == STABLE_LAST) begin
                        state_q   <= ST_RUN;
                        sys_rst_q <= 1'b0;
                        ready_q   <= 1'b1;
                        retry_q   <= '0;
                        timer_q   <= '0;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!locked_s_q) begin
                        state_q   <= ST_RESET;
                        pll_rst_q <= 1'b1;
                        sys_rst_q <= 1'b1;
                        ready_q   <= 1'b0;
                        timer_q   <= '0;
                        if (loss_q != 8'hFF) begin
                            loss_q <= loss_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state_q   <= ST_RESET;
                    pll_rst_q <= 1'b1;
                    sys_rst_q <= 1'b1;
                    ready_q   <= 1'b0;
                    timer_q   <= '0;
                end
            endcase

`ifdef JTFRAME_PLL_PHASE_EN
            done_meta_q <= pll_phasedone;
            done_s_q    <= done_meta_q;

            if (!stay_run) begin
                // Abort: remaining steps are dropped.
                ph_state_q  <= PH_IDLE;
                steps_q     <= '0;
                pulse_q     <= 1'b0;
                busy_q      <= 1'b0;
                phasestep_q <= 1'b0;
            end else begin
                case (ph_state_q)
                    PH_IDLE: begin
                        if (phase_req && (phase_steps != 6'd0)) begin
                            updn_q      <= phase_dir;
                            steps_q     <= phase_steps;
                            busy_q      <= 1'b1;
                            phasestep_q <= 1'b1;
                            pulse_q     <= 1'b0;
                            ph_state_q  <= PH_PULSE;
                        end
                    end
                    PH_PULSE: begin
                        // phasestep is held for two clk cycles per step
                        if (pulse_q) begin
                            phasestep_q <= 1'b0;
                            ph_state_q  <= PH_WLOW;
                        end else begin
                            pulse_q <= 1'b1;
                        end
                    end
                    PH_WLOW: begin
                        if (!done_s_q) begin
                            ph_state_q <= PH_WHIGH;
                        end
                    end
                    PH_WHIGH: begin
                        if (done_s_q) begin
                            if (steps_q == 6'd1) begin
                                steps_q    <= '0;
                                busy_q     <= 1'b0;
                                ph_state_q <= PH_IDLE;
                            end else begin
                                steps_q     <= steps_q - 6'd1;
                                phasestep_q <= 1'b1;
                                pulse_q     <= 1'b0;
                                ph_state_q  <= PH_PULSE;
                            end
                        end
                    end
                    default: begin
                        ph_state_q  <= PH_IDLE;
                        busy_q      <= 1'b0;
                        phasestep_q <= 1'b0;
                    end
                endcase
            end
`endif
        end
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst   = sys_rst_q;
    assign ready     = ready_q;
    assign fail      = fail_q;
    assign retry_cnt = retry_q;
    assign loss_cnt  = loss_q;

`ifdef JTFRAME_PLL_PHASE_EN
    assign phase_busy    = busy_q;
    assign pll_phasestep = phasestep_q;
    assign pll_updn      = updn_q;
    assign pll_cntsel    = PHASE_CNT;
`endif

endmodule

// File: tb/tb_jtframe_pll_seq.sv
// Testbench for jtframe_pll_seq. Uses a short stability window so that the
// 256-loss saturation scenario fits in a reasonable run time. Expected
// latencies are derived from the behaviour: 2 synchronizer flops plus the
// state register give 3 cycles from an input change to a registered reaction.
module tb_jtframe_pll_seq;

    localparam int RST_C    = 16;
    localparam int STAB_C   = 128;
    localparam int TO_C     = 1000;
    localparam int MAXR     = 7;
    localparam int SYNC_LAT = 3;

    localparam int S_PLLRST = 0;
    localparam int S_SYSRST = 1;
    localparam int S_BUSY   = 2;
    localparam int S_STEP   = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic       pll_rst, sys_rst, ready, fail;
    logic [2:0] retry_cnt;
    logic [7:0] loss_cnt;
    logic       phase_busy, pll_phasestep, pll_updn;
    logic [4:0] pll_cntsel;
    logic       phase_req = 1'b0;
    logic       phase_dir = 1'b0;
    logic [5:0] phase_steps = 6'd0;
    logic       pll_phasedone = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    jtframe_pll_seq #(
        .RST_CYCLES   (RST_C),
        .STABLE_CYCLES(STAB_C),
        .TIMEOUT      (TO_C),
        .MAX_RETRY    (MAXR)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pll_locked   (pll_locked),
        .pll_rst      (pll_rst),
        .sys_rst      (sys_rst),
        .ready        (ready),
        .fail         (fail),
        .retry_cnt    (retry_cnt),
        .loss_cnt     (loss_cnt)
`ifdef JTFRAME_PLL_PHASE_EN
        ,
        .phase_req    (phase_req),
        .phase_dir    (phase_dir),
        .phase_steps  (phase_steps),
        .phase_busy   (phase_busy),
        .pll_phasestep(pll_phasestep),
        .pll_updn     (pll_updn),
        .pll_cntsel   (pll_cntsel),
        .pll_phasedone(pll_phasedone)
`endif
    );

`ifndef JTFRAME_PLL_PHASE_EN
    assign phase_busy    = 1'b0;
    assign pll_phasestep = 1'b0;
    assign pll_updn      = 1'b0;
    assign pll_cntsel    = 5'd0;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            S_PLLRST: return pll_rst;
            S_SYSRST: return sys_rst;
            S_BUSY:   return phase_busy;
            S_STEP:   return pll_phasestep;
            default:  return 1'bx;
        endcase
    endfunction

    // Ticks until the selected output equals val; -1 if the bound expires.
    task automatic wait_sig(input int sel, input logic val, input int limit, output int n);
        n = 0;
        while (sig(sel) !== val && n < limit) begin
            tick();
            n++;
        end
        if (sig(sel) !== val) n = -1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        pll_locked = 1'b0;
        phase_req = 1'b0;
        pll_phasedone = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        int n, e;
        rst_n = 1'b0;
        pll_locked = 1'b0;
        phase_req = 1'b0;
        pll_phasedone = 1'b1;
        repeat (3) tick();
        exp_q.push_back(int'({1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0, 1'b0}));
        e = exp_q.pop_front();
        n = int'({pll_rst, sys_rst, ready, fail, retry_cnt, loss_cnt, phase_busy, pll_phasestep});
        n_cmp++;
        if (n !== e) begin
            n_bad++;
            $display("FAIL reset_state: got 0x%0h expected 0x%0h", n, e);
        end
        $display("reset_state: outputs 0x%0h", n);
        rst_n = 1'b1;
        exp_q.push_back(RST_C);
        wait_sig(S_PLLRST, 1'b0, 200, n);
        e = exp_q.pop_front();
        n_cmp++;
        if (n !== e) begin
            n_bad++;
            $display("FAIL pll_rst_width: got %0d expected %0d", n, e);
        end
        $display("pll_rst_width: %0d cycles", n);
    endtask

    task automatic test_lock();
        int n, e;
        repeat (100) tick();
        exp_q.push_back(int'(2'b01));
        e = exp_q.pop_front();
        n = int'({pll_rst, sys_rst});
        n_cmp++;
        if (n !== e) begin
            n_bad++;
            $display("FAIL wait_lock_outputs: got %0d expected %0d", n, e);
        end
        pll_locked = 1'b1;
        exp_q.push_back(STAB_C + SYNC_LAT);
        wait_sig(S_SYSRST, 1'b0, 1000, n);
        e = exp_q.pop_front();
        n_cmp++;
        if (n !== e) begin
            n_bad++;
            $display("FAIL lock_to_release: got %0d expected %0d", n, e);
        end
        $display("lock_to_release: %0d cycles", n);
        exp_q.push_back(int'({1'b1, 1'b0, 3'd0, 8'd0}));
        e = exp_q.pop_front();
        n = int'({ready, fail, retry_cnt, loss_cnt});
        n_cmp++;
        if (n !== e) begin
            n_bad++;
            $display("FAIL run_outputs: got 0x%0h expected 0x%0h", n, e);
        end
    endtask

    task automatic test_glitch();
        int n, e;
        apply_reset();
        wait_sig(S_PLLRST, 1'b0, 100, n);
        pll_locked = 1'b1;
        repeat (20) tick();
        pll_locked = 1'b0;
        repeat (3) tick();
        pll_locked = 1'b1;
        exp_q.push_back(STAB_C + SYNC_LAT);
        wait_sig(S_SYSRST, 1'b0, 1000, n);
        e = exp_q.pop_front();
        n_cmp++;
        if (n !== e) begin
            n_bad++;
            $display("FAIL glitch_restart: got %0d expected %0d", n, e);
        end
        $display("glitch_restart: %0d cycles after relock", n);
        exp_q.push_back(int'({1'b0, 3'd0, 1'b0}));
        e = exp_q.pop_front();
        n = int'({pll_rst, retry_cnt, fail});
        n_cmp++;
        if (n !== e) begin
            n_bad++;
            $display("FAIL glitch_no_retry: got 0x%0h expected 0x%0h", n, e);
        end
    endtask

    task automatic test_loss();
        int n, e, exp_loss;
        pll_locked = 1'b0;
        exp_q.push_back(SYNC_LAT);
        wait_sig(S_SYSRST, 1'b1, 20, n);
        e = exp_q.pop_front();
        n_cmp++;
        if (n !== e) begin
            n_bad++;
            $display("FAIL loss_reaction: got %0d expected %0d", n, e);
        end
        $display("loss_reaction: %0d cycles", n);
        exp_q.push_back(int'({1'b1, 1'b0, 8'd1}));
        e = exp_q.pop_front();
        n = int'({pll_rst, ready, loss_cnt});
        n_cmp++;
        if (n !== e) begin
            n_bad++;
            $display("FAIL loss_outputs: got 0x%0h expected 0x%0h", n, e);
        end
        exp_q.push_back(RST_C);
        wait_sig(S_PLLRST, 1'b0, 100, n);
        e = exp_q.pop_front();
        n_cmp++;
        if (n !== e) begin
            n_bad++;
            $display("FAIL loss_repulse: got %0d expected %0d", n, e);
        end
        pll_locked = 1'b1;
        exp_q.push_back(STAB_C + SYNC_LAT);
        wait_sig(S_SYSRST, 1'b0, 1000, n);
        e = exp_q.pop_front();
        n_cmp++;
        if (n !== e) begin
            n_bad++;
            $display("FAIL loss_resequence: got %0d expected %0d", n, e);
        end
        exp_loss = 1;
        for (int i = 2; i <= 256; i++) begin
            pll_locked = 1'b0;
            exp_loss = (exp_loss < 255) ? exp_loss + 1 : 255;
            exp_q.push_back(exp_loss);
            wait_sig(S_SYSRST, 1'b1, 20, n);
            e = exp_q.pop_front();
            n = int'(loss_cnt);
            n_cmp++;
            if (n !== e) begin
                n_bad++;
                $display("FAIL loss_count[%0d]: got %0d expected %0d", i, n, e);
            end
            if (i >= 254) $display("loss_count[%0d]: %0d", i, n);
            wait_sig(S_PLLRST, 1'b0, 100, n);
            pll_locked = 1'b1;
            wait_sig(S_SYSRST, 1'b0, 1000, n);
        end
    endtask

`ifdef JTFRAME_PLL_PHASE_EN
    task automatic test_phase();
        int n, e, pulses;
        // Zero steps: no-op.
        phase_dir = 1'b1;
        phase_steps = 6'd0;
        phase_req = 1'b1;
        tick();
        phase_req = 1'b0;
        repeat (3) tick();
        exp_q.push_back(0);
        e = exp_q.pop_front();
        n = int'({phase_busy, pll_phasestep});
        n_cmp++;
        if (n !== e) begin
            n_bad++;
            $display("FAIL phase_zero_steps: got %0d expected %0d", n, e);
        end
        phase_steps = 6'd3;
        phase_req = 1'b1;
        tick();
        phase_req = 1'b0;
        exp_q.push_back(1);
        e = exp_q.pop_front();
        n = int'(phase_busy);
        n_cmp++;
        if (n !== e) begin
            n_bad++;
            $display("FAIL phase_busy_set: got %0d expected %0d", n, e);
        end
        for (int k = 0; k < 3; k++) begin
            wait_sig(S_STEP, 1'b1, 30, n);
            exp_q.push_back(int'({1'b1, 5'd1}));
            e = exp_q.pop_front();
            n = int'({pll_updn, pll_cntsel});
            n_cmp++;
            if (n !== e) begin
                n_bad++;
                $display("FAIL phase_updn_cntsel[%0d]: got 0x%0h expected 0x%0h", k, n, e);
            end
            exp_q.push_back(2);
            wait_sig(S_STEP, 1'b0, 30, n);
            e = exp_q.pop_front();
            n_cmp++;
            if (n !== e) begin
                n_bad++;
                $display("FAIL phase_pulse_width[%0d]: got %0d expected %0d", k, n, e);
            end
            $display("phase_step[%0d]: pulse %0d cycles", k, n);
            pll_phasedone = 1'b0;
            repeat (4) tick();
            pll_phasedone = 1'b1;
        end
        exp_q.push_back(SYNC_LAT);
        wait_sig(S_BUSY, 1'b0, 30, n);
        e = exp_q.pop_front();
        n_cmp++;
        if (n !== e) begin
            n_bad++;
            $display("FAIL phase_busy_clear: got %0d expected %0d", n, e);
        end
        pulses = 0;
        for (int j = 0; j < 20; j++) begin
            tick();
            if (pll_phasestep) pulses++;
        end
        exp_q.push_back(0);
        e = exp_q.pop_front();
        n_cmp++;
        if (pulses !== e) begin
            n_bad++;
            $display("FAIL phase_extra_pulses: got %0d expected %0d", pulses, e);
        end
    endtask

    task automatic test_phase_abort();
        int n, e, pulses;
        phase_dir = 1'b0;
        phase_steps = 6'd5;
        phase_req = 1'b1;
        tick();
        phase_req = 1'b0;
        exp_q.push_back(int'({1'b1, 1'b0}));
        e = exp_q.pop_front();
        n = int'({phase_busy, pll_updn});
        n_cmp++;
        if (n !== e) begin
            n_bad++;
            $display("FAIL abort_start: got %0d expected %0d", n, e);
        end
        wait_sig(S_STEP, 1'b0, 30, n);
        pll_phasedone = 1'b0;
        repeat (4) tick();
        pll_phasedone = 1'b1;
        pll_locked = 1'b0;
        repeat (SYNC_LAT) tick();
        exp_q.push_back(int'({1'b0, 1'b0, 1'b1}));
        e = exp_q.pop_front();
        n = int'({phase_busy, pll_phasestep, sys_rst});
        n_cmp++;
        if (n !== e) begin
            n_bad++;
            $display("FAIL abort_outputs: got %0d expected %0d", n, e);
        end
        pulses = 0;
        for (int j = 0; j < 40; j++) begin
            if (j == 5) phase_req = 1'b1;
            if (j == 6) phase_req = 1'b0;
            tick();
            if (pll_phasestep || phase_busy) pulses++;
        end
        exp_q.push_back(0);
        e = exp_q.pop_front();
        n_cmp++;
        if (pulses !== e) begin
            n_bad++;
            $display("FAIL abort_no_pulses: got %0d expected %0d", pulses, e);
        end
        $display("phase_abort: %0d busy/step cycles after abort", pulses);
    endtask

    task automatic bring_up();
        int n, e;
        apply_reset();
        wait_sig(S_PLLRST, 1'b0, 100, n);
        pll_locked = 1'b1;
        exp_q.push_back(STAB_C + SYNC_LAT);
        wait_sig(S_SYSRST, 1'b0, 1000, n);
        e = exp_q.pop_front();
        n_cmp++;
        if (n !== e) begin
            n_bad++;
            $display("FAIL bring_up: got %0d expected %0d", n, e);
        end
    endtask
`endif

    task automatic test_timeout();
        int n, e;
        apply_reset();
        wait_sig(S_PLLRST, 1'b0, 100, n);
        for (int i = 1; i <= 9; i++) begin
            exp_q.push_back(TO_C);
            wait_sig(S_PLLRST, 1'b1, TO_C + 100, n);
            e = exp_q.pop_front();
            n_cmp++;
            if (n !== e) begin
                n_bad++;
                $display("FAIL timeout_period[%0d]: got %0d expected %0d", i, n, e);
            end
            exp_q.push_back(int'({3'((i < MAXR) ? i : MAXR), (i >= MAXR) ? 1'b1 : 1'b0}));
            e = exp_q.pop_front();
            n = int'({retry_cnt, fail});
            n_cmp++;
            if (n !== e) begin
                n_bad++;
                $display("FAIL retry_fail[%0d]: got 0x%0h expected 0x%0h", i, n, e);
            end
            $display("timeout[%0d]: wait %0d cycles retry_cnt %0d fail %0d", i, TO_C, retry_cnt, fail);
            exp_q.push_back(RST_C);
            wait_sig(S_PLLRST, 1'b0, 100, n);
            e = exp_q.pop_front();
            n_cmp++;
            if (n !== e) begin
                n_bad++;
                $display("FAIL timeout_repulse[%0d]: got %0d expected %0d", i, n, e);
            end
        end
        pll_locked = 1'b1;
        wait_sig(S_SYSRST, 1'b0, 1000, n);
        exp_q.push_back(int'({3'd0, 1'b1, 1'b1}));
        e = exp_q.pop_front();
        n = int'({retry_cnt, fail, ready});
        n_cmp++;
        if (n !== e) begin
            n_bad++;
            $display("FAIL fail_sticky: got 0x%0h expected 0x%0h", n, e);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_glitch();
        test_loss();
`ifdef JTFRAME_PLL_PHASE_EN
        bring_up();
        test_phase();
        test_phase_abort();
`endif
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
